queue_controller: RTL and testbench

Sequencer for a queue built from `numOfWord` word cells of `numOfBit` bits each.
- Owns the write and read pointers and the occupancy count.
- Generates each cell's one-hot row select and write-enable strobe, using a three-phase SETUP / STROBE / HOLD write sequence.
- Muxes the flattened cell outputs back into a single pop-data port.
- Sits between the queue's user (push/pop handshake) and the passive word-cell array.

---
 rtl/queue_pkg.sv | 16 +
 rtl/queue_controller_if.sv | 26 ++
 rtl/queue_controller_row_decoder.sv | 15 +
 rtl/queue_controller.sv | 102 ++++++++++
 tb/tb_queue_controller.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/queue_pkg.sv
// Shared types, default geometry and one-hot helper for the queue controller.
package queue_pkg;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} wr_state_t;

  localparam int unsigned DEF_NUM_OF_BIT  = 4;
  localparam int unsigned DEF_NUM_OF_WORD = 8;
  localparam int unsigned MAX_WORDS       = 64;
  localparam int unsigned MAX_PTR_W       = 6;

  function automatic logic [MAX_WORDS-1:0] onehot(input logic [MAX_PTR_W-1:0] idx);
    onehot      = '0;
    onehot[idx] = 1'b1;
  endfunction

endpackage

// File: rtl/queue_controller_if.sv
// User-side push/pop handshake bundle of the queue controller.
interface queue_controller_if #(
  parameter int unsigned numOfBit  = 4,
  parameter int unsigned numOfWord = 8
);
  localparam int unsigned ptrW = $clog2(numOfWord);

  logic                Push;
  logic [numOfBit-1:0] PushData;
  logic                PushReady;
  logic                Pop;
  logic [numOfBit-1:0] PopData;
  logic                Empty;
  logic                Full;
  logic [ptrW:0]       Count;

  modport master (
    output Push, PushData, Pop,
    input  PushReady, PopData, Empty, Full, Count
  );

  modport slave (
    input  Push, PushData, Pop,
    output PushReady, PopData, Empty, Full, Count
  );
endinterface

// File: rtl/queue_controller_row_decoder.sv
// Binary pointer to one-hot row select; all zeros when disabled.
module row_decoder
  import queue_pkg::*;
#(
  parameter  int unsigned numOfWord = DEF_NUM_OF_WORD,
  localparam int unsigned ptrW      = $clog2(numOfWord)
) (
  input  logic [ptrW-1:0]      ptr,
  input  logic                 en,
  output logic [numOfWord-1:0] row_c
);

  assign row_c = en ? numOfWord'(onehot(MAX_PTR_W'(ptr))) : '0;

endmodule

// File: rtl/queue_controller.sv
// Queue sequencer: pointers, occupancy and three-phase cell write timing.
// Optional sticky Overflow/Underflow ports under QUEUE_CTRL_ERR_FLAGS_EN.
module queue_controller
  import queue_pkg::*;
#(
  parameter  int unsigned numOfBit  = DEF_NUM_OF_BIT,
  parameter  int unsigned numOfWord = DEF_NUM_OF_WORD,
  localparam int unsigned ptrW      = $clog2(numOfWord),
  localparam int unsigned cntW      = ptrW + 1
) (
  input  logic                          Clk,
  input  logic                          Rst_n,
  queue_controller_if.slave             bus,
  output logic [numOfWord-1:0]          RowSelect,
  output logic                          WriteEn,
  output logic [numOfBit-1:0]           CellDataIn,
  input  logic [numOfWord*numOfBit-1:0] CellDataOut
`ifdef QUEUE_CTRL_ERR_FLAGS_EN
  ,
  output logic                          Overflow,
  output logic                          Underflow
`endif
);

  wr_state_t           state, state_nxt;
  logic [ptrW-1:0]     wr_ptr, rd_ptr;
  logic [cntW-1:0]     count, count_nxt;
  logic                empty, full;
  logic                push_acc, pop_acc, commit;
  logic                row_en;
  logic [numOfWord-1:0] row_nxt;

  assign bus.Count     = count;
  assign bus.Empty     = empty;
  assign bus.Full      = full;
  assign bus.PushReady = (state == IDLE) && (count < cntW'(numOfWord));
  assign bus.PopData   = CellDataOut[rd_ptr*numOfBit +: numOfBit];

  assign push_acc = bus.Push && bus.PushReady;
  assign pop_acc  = bus.Pop && !empty;
  assign commit   = (state == HOLD);

  // Next-state and next-count; the in-flight word is counted only at commit.
  always_comb begin
    state_nxt = state;
    count_nxt = count + cntW'(commit) - cntW'(pop_acc);
    unique case (state)
      IDLE:    if (push_acc) state_nxt = SETUP;
      SETUP:   state_nxt = STROBE;
      STROBE:  state_nxt = HOLD;
      HOLD:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // wr_ptr only moves on HOLD->IDLE, where the decoder is disabled anyway.
  assign row_en = (state_nxt != IDLE);

  row_decoder #(.numOfWord(numOfWord)) u_row_decoder (
    .ptr   (wr_ptr),
    .en    (row_en),
    .row_c (row_nxt)
  );

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state      <= IDLE;
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      empty      <= 1'b1;
      full       <= 1'b0;
      RowSelect  <= '0;
      WriteEn    <= 1'b0;
      CellDataIn <= '0;
    end else begin
      state     <= state_nxt;
      count     <= count_nxt;
      empty     <= (count_nxt == '0);
      full      <= (count_nxt == cntW'(numOfWord));
      RowSelect <= row_nxt;
      WriteEn   <= (state_nxt == STROBE);
      if (push_acc) CellDataIn <= bus.PushData;
      if (commit)   wr_ptr     <= wr_ptr + ptrW'(1);
      if (pop_acc)  rd_ptr     <= rd_ptr + ptrW'(1);
    end
  end

`ifdef QUEUE_CTRL_ERR_FLAGS_EN
  // Sticky illegal-request flags, cleared only by reset.
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      Overflow  <= 1'b0;
      Underflow <= 1'b0;
    end else begin
      if (bus.Push && !bus.PushReady && full) Overflow  <= 1'b1;
      if (bus.Pop && empty)                   Underflow <= 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_controller.sv
// Directed self-checking bench for queue_controller with a behavioural cell array.
module tb_queue_controller;

  localparam int unsigned NB = 4;
  localparam int unsigned NW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NW-1:0] row_select;
  logic          write_en;
  logic [NB-1:0] cell_data_in;
  logic [NW*NB-1:0] cell_data_out;
  logic [NB-1:0] mem [NW];
`ifdef QUEUE_CTRL_ERR_FLAGS_EN
  logic          overflow, underflow;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  queue_controller_if #(.numOfBit(NB), .numOfWord(NW)) bus ();

  queue_controller #(.numOfBit(NB), .numOfWord(NW)) dut (
    .Clk         (clk),
    .Rst_n       (rst_n),
    .bus         (bus),
    .RowSelect   (row_select),
    .WriteEn     (write_en),
    .CellDataIn  (cell_data_in),
    .CellDataOut (cell_data_out)
`ifdef QUEUE_CTRL_ERR_FLAGS_EN
    ,
    .Overflow    (overflow),
    .Underflow   (underflow)
`endif
  );

  always #5 clk = ~clk;

  // Passive word-cell array.
  always @(posedge clk) begin
    for (int i = 0; i < NW; i++)
      if (write_en && row_select[i]) mem[i] <= cell_data_in;
  end

  always_comb begin
    for (int i = 0; i < NW; i++) cell_data_out[i*NB +: NB] = mem[i];
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_assert++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  task automatic push_word(input logic [NB-1:0] v, input logic [NW-1:0] row);
    bus.Push = 1'b1;
    bus.PushData = v;
    tick();
    bus.Push = 1'b0;
    check("setup_row", 32'(row_select), 32'(row));
    check("setup_we", 32'(write_en), 0);
    check("setup_data", 32'(cell_data_in), 32'(v));
    check("setup_ready", 32'(bus.PushReady), 0);
    tick();
    check("strobe_row", 32'(row_select), 32'(row));
    check("strobe_we", 32'(write_en), 1);
    tick();
    check("hold_row", 32'(row_select), 32'(row));
    check("hold_we", 32'(write_en), 0);
    check("hold_data", 32'(cell_data_in), 32'(v));
    tick();
    check("idle_row", 32'(row_select), 0);
  endtask

  task automatic pop_word(input logic [NB-1:0] exp);
    check("pop_data", 32'(bus.PopData), 32'(exp));
    bus.Pop = 1'b1;
    tick();
    bus.Pop = 1'b0;
  endtask

  initial begin
    bus.Push = 1'b0;
    bus.Pop = 1'b0;
    bus.PushData = '0;
    for (int i = 0; i < NW; i++) mem[i] = '0;

    // Reset then idle
    do_reset();
    tick(); tick(); tick();
    check("rst_empty", 32'(bus.Empty), 1);
    check("rst_full", 32'(bus.Full), 0);
    check("rst_count", 32'(bus.Count), 0);
    check("rst_row", 32'(row_select), 0);
    check("rst_we", 32'(write_en), 0);
    check("rst_ready", 32'(bus.PushReady), 1);
    check("rst_cdi", 32'(cell_data_in), 0);
`ifdef QUEUE_CTRL_ERR_FLAGS_EN
    check("rst_ovf", 32'(overflow), 0);
    check("rst_unf", 32'(underflow), 0);
`endif

    // Single push of 15 into row 0
    push_word(4'd15, 8'h01);
    check("p15_count", 32'(bus.Count), 1);
    check("p15_empty", 32'(bus.Empty), 0);
    check("p15_ready", 32'(bus.PushReady), 1);
    pop_word(4'd15);
    check("p15_pop_empty", 32'(bus.Empty), 1);
    check("p15_pop_count", 32'(bus.Count), 0);

    // Fill with 1..8 (rows 1..7 then 0), then an ignored push of 9
    for (int v = 1; v <= 8; v++) push_word(NB'(v), NW'(1) << (v % NW));
    check("fill_full", 32'(bus.Full), 1);
    check("fill_count", 32'(bus.Count), 8);
    check("fill_ready", 32'(bus.PushReady), 0);
    bus.Push = 1'b1;
    bus.PushData = 4'd9;
    tick();
    bus.Push = 1'b0;
    check("ovf_row", 32'(row_select), 0);
    check("ovf_we", 32'(write_en), 0);
    check("ovf_count", 32'(bus.Count), 8);
    check("ovf_cdi", 32'(cell_data_in), 8);
`ifdef QUEUE_CTRL_ERR_FLAGS_EN
    check("ovf_flag", 32'(overflow), 1);
`endif
    for (int v = 1; v <= 8; v++) pop_word(NB'(v));
    check("drain_empty", 32'(bus.Empty), 1);
    check("drain_full", 32'(bus.Full), 0);

    // Pop while empty is ignored
`ifdef QUEUE_CTRL_ERR_FLAGS_EN
    check("unf_before", 32'(underflow), 0);
`endif
    bus.Pop = 1'b1;
    tick();
    bus.Pop = 1'b0;
    check("unf_count", 32'(bus.Count), 0);
    check("unf_empty", 32'(bus.Empty), 1);
    tick();
`ifdef QUEUE_CTRL_ERR_FLAGS_EN
    check("unf_sticky", 32'(underflow), 1);
    check("ovf_sticky", 32'(overflow), 1);
    do_reset();
    check("rst2_ovf", 32'(overflow), 0);
    check("rst2_unf", 32'(underflow), 0);
`endif

    // Wrap-around: fill 10..17, pop 3, push 20..22 into rows 0..2
    do_reset();
    for (int i = 0; i < 8; i++) push_word(NB'(10 + i), NW'(1) << i);
    pop_word(4'd10);
    pop_word(4'd11);
    pop_word(4'd12);
    check("wrap_count5", 32'(bus.Count), 5);
    push_word(4'd4, 8'h01);
    push_word(4'd5, 8'h02);
    push_word(4'd6, 8'h04);
    check("wrap_count8", 32'(bus.Count), 8);
    for (int v = 13; v <= 15; v++) pop_word(NB'(v));
    for (int v = 0; v <= 1; v++) pop_word(NB'(v));
    pop_word(4'd4);
    pop_word(4'd5);
    pop_word(4'd6);
    check("wrap_empty", 32'(bus.Empty), 1);

    // Pop coincident with commit edge keeps Count
    do_reset();
    push_word(4'd1, 8'h01);
    push_word(4'd2, 8'h02);
    bus.Push = 1'b1;
    bus.PushData = 4'd3;
    tick();
    bus.Push = 1'b0;
    tick();
    tick();
    check("coin_pre_count", 32'(bus.Count), 2);
    check("coin_pre_row", 32'(row_select), 32'h04);
    bus.Pop = 1'b1;
    tick();
    bus.Pop = 1'b0;
    check("coin_count", 32'(bus.Count), 2);
    check("coin_head", 32'(bus.PopData), 2);
    push_word(4'd7, 8'h08);
    pop_word(4'd2);
    pop_word(4'd3);
    pop_word(4'd7);
    check("coin_empty", 32'(bus.Empty), 1);

    // Reset asserted during STROBE discards the write
    push_word(4'd9, 8'h10);
    bus.Push = 1'b1;
    bus.PushData = 4'd5;
    tick();
    bus.Push = 1'b0;
    tick();
    check("rstw_we_pre", 32'(write_en), 1);
    check("rstw_count_pre", 32'(bus.Count), 1);
    rst_n = 1'b0;
    tick();
    check("rstw_we", 32'(write_en), 0);
    check("rstw_count", 32'(bus.Count), 0);
    check("rstw_empty", 32'(bus.Empty), 1);
    check("rstw_row", 32'(row_select), 0);
    check("rstw_cdi", 32'(cell_data_in), 0);
    rst_n = 1'b1;
    tick();
    check("rstw_ready", 32'(bus.PushReady), 1);
    check("rstw_count_post", 32'(bus.Count), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
